data_mem_port: RTL



---
 rtl/data_mem_port.sv | 123 ++++++++++++
 1 files changed

// File: rtl/data_mem_port.sv
// ============================================================================
// Module   : data_mem_port
// Purpose  : Memory-side responder for register-bank MW/MR micro-operations,
//            with programmable wait states over a 16-bit word array.
// Options  : MEM_PROTECT_EN - writes below PROT_LIMIT are refused with err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_port #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2,
  parameter int PROT_LIMIT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        MC,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       WRdata,
  output logic [15:0]       Mdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int         DEPTH   = 2 ** ADDR_W;
  localparam logic [3:0] WS_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         wdata_q;
  logic                wr_q;
  logic [3:0]          cnt_q;
  logic [15:0]         mdata_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [15:0]         mem_q [DEPTH];
  logic                wr_blocked;
  logic                mem_we_d;

`ifdef MEM_PROTECT_EN
  // Protected writes still run the full timing; only the array update is refused.
  assign wr_blocked = wr_q && (ADDR_W'(addr_q) < ADDR_W'(PROT_LIMIT));
`else
  assign wr_blocked = 1'b0;
`endif

  // A reset at the ACCESS edge must also abort the array update.
  assign mem_we_d = rst_n && (state_q == S_ACCESS) && wr_q && !wr_blocked;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      wr_q    <= 1'b0;
      cnt_q   <= 4'd0;
      mdata_q <= 16'h0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if ((MC == 2'b01) || (MC == 2'b10)) begin
            addr_q  <= addr;
            wdata_q <= WRdata;
            wr_q    <= MC[0];
            cnt_q   <= WS_INIT;
            busy_q  <= 1'b1;
            state_q <= (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
          end else if (MC == 2'b11) begin
            err_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_ACCESS;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ACCESS: begin
          if (!wr_q) begin
            mdata_q <= mem_q[addr_q];
          end
          busy_q  <= 1'b0;
          done_q  <= !wr_blocked;
          err_q   <= wr_blocked;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Array contents survive reset, so this storage has no reset branch.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign Mdata = mdata_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

`default_nettype wire
